// File: rtl/rotate_arbiter.sv
// rotate_arbiter: two-requester round-robin front end for a shared DW-bit
// left/right rotate. One request is granted at a time, rotated in a registered
// execute stage, and the tagged result is held until the consumer takes it.
module rotate_arbiter #(
  parameter int DW = 8,
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [AW-1:0] req0_amt,
  input  logic          req0_dir,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [AW-1:0] req1_amt,
  input  logic          req1_dir,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_y,
  output logic          out_id,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] a_q, a_d;
  logic [AW-1:0] amt_q, amt_d;
  logic          dir_q, dir_d;
  logic          id_q, id_d;
  logic [DW-1:0] out_y_q, out_y_d;
  logic          out_id_q, out_id_d;
  logic          out_valid_q, out_valid_d;

  logic [1:0]    grant;
  logic [DW-1:0] rot_left;
  logic [DW-1:0] rot_right;

  // Round-robin pick: a lone requester wins; on contention the one not served last wins.
  always_comb begin
    grant = 2'b00;
    if (req0_valid && req1_valid) begin
      grant = last_grant_q ? 2'b01 : 2'b10;
    end else begin
      grant = {req1_valid, req0_valid};
    end
  end

  // Ready is suppressed while reset is held so no requester believes it was
  // accepted on an edge where the capture is discarded.
  assign req0_ready = (state_q == IDLE) && grant[0] && !reset;
  assign req1_ready = (state_q == IDLE) && grant[1] && !reset;

  // Rotation as a per-bit mux: AW-bit index arithmetic wraps modulo DW, so
  // amt = 0 passes the operand through and no shift ever goes out of range.
  for (genvar gi = 0; gi < DW; gi++) begin : g_rot
    logic [AW-1:0] idx_l;
    logic [AW-1:0] idx_r;
    assign idx_l         = AW'(gi) - amt_q;
    assign idx_r         = AW'(gi) + amt_q;
    assign rot_left[gi]  = a_q[idx_l];
    assign rot_right[gi] = a_q[idx_r];
  end

  // Next-state logic: capture on grant, rotate in EXEC, hold result in DONE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    a_d          = a_q;
    amt_d        = amt_q;
    dir_d        = dir_q;
    id_d         = id_q;
    out_y_d      = out_y_q;
    out_id_d     = out_id_q;
    out_valid_d  = out_valid_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          a_d          = grant[1] ? req1_a   : req0_a;
          amt_d        = grant[1] ? req1_amt : req0_amt;
          dir_d        = grant[1] ? req1_dir : req0_dir;
          id_d         = grant[1];
          last_grant_d = grant[1];
          state_d      = EXEC;
        end
      end
      EXEC: begin
        out_y_d     = dir_q ? rot_right : rot_left;
        out_id_d    = id_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      amt_q        <= '0;
      dir_q        <= 1'b0;
      id_q         <= 1'b0;
      out_y_q      <= '0;
      out_id_q     <= 1'b0;
      out_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      a_q          <= a_d;
      amt_q        <= amt_d;
      dir_q        <= dir_d;
      id_q         <= id_d;
      out_y_q      <= out_y_d;
      out_id_q     <= out_id_d;
      out_valid_q  <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: doc/rotate_arbiter.md
Name: rotate_arbiter

Overview:
Two-requester round-robin controller that shares one 8-bit left/right rotate datapath. Each requester presents an operand, a rotate amount and a direction through a valid/ready handshake. The block grants one request at a time, computes the rotation in a registered execute stage, and holds a tagged result until the consumer accepts it. It sits between the requesting FSMs and the multifunction barrel-shifter datapath.

Parameters:
DW, 8, data width in bits; must be a power of two.
AW, 3, rotate-amount width; equals log2(DW).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-high reset.
req0_valid  input  1  requester 0 has a request.
req0_ready  output  1  requester 0 request accepted this cycle.
req0_a  input  DW  requester 0 operand.
req0_amt  input  AW  requester 0 rotate amount.
req0_dir  input  1  requester 0 direction: 0 = left, 1 = right.
req1_valid, req1_ready, req1_a, req1_amt, req1_dir  same as above, for requester 1.
out_valid  output  1  result is valid.
out_ready  input  1  consumer accepts the result.
out_y  output  DW  rotated result.
out_id  output  1  index of the requester that owns out_y.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset and clock: one clock; reset is synchronous and active-high.
- Reset values: state = IDLE, out_valid = 0, out_y = 0, out_id = 0, busy = 0, last_grant = 1, so requester 0 has first priority. All captured operand registers are cleared.
- FSM states are IDLE, EXEC and DONE.
- IDLE:
  - Arbitration is combinational.
  - Only one valid: grant that requester.
  - Both valid: grant the requester that is not last_grant.
  - reqN_ready = (state == IDLE) and grantN. At most one ready is high in any cycle.
  - On a grant edge, capture a, amt, dir and id, set last_grant = id, then go to EXEC.
  - No request valid: stay in IDLE.
- EXEC (one cycle):
  - Left: out_y = (a << amt) | (a >> (DW-amt)).
  - Right: out_y = (a >> amt) | (a << (DW-amt)).
  - Shifts are done in 2*DW width, or as the equivalent mux tree, so amt = 0 returns a unchanged. There are no X and no out-of-range shifts.
  - Register out_y and out_id, set out_valid = 1, go to DONE.
- DONE:
  - out_valid stays high, and out_y and out_id stay stable, until out_ready is sampled high.
  - On that edge, clear out_valid and go to IDLE.
  - No new request is accepted in DONE.
- Latency and throughput:
  - Grant at edge k puts out_valid high after edge k+1.
  - With out_ready held high, out_valid is a single-cycle pulse.
  - Minimum spacing between grants is 3 cycles.
- A requester must hold valid and its fields stable until it sees ready. The block does not assume this, because it samples only on the grant edge.
- Dropping valid before a grant cancels that request with no side effects.
- out_ready while out_valid is low is ignored.
- Reset asserted in any state aborts the in-flight operation the next edge: no result is emitted, and priority returns to requester 0.
- A starved requester is guaranteed a grant within one service of the other requester.
- busy = (state != IDLE).

Test Plan:
1. Reset for 2 cycles, then idle: out_valid = 0, out_y = 0, busy = 0, both ready = 0. req0 with a = 8'b10010011, amt = 1, dir = 0, out_ready = 1: req0_ready pulses 1 cycle, 2 cycles later out_y = 8'b00100111, out_id = 0.
2. Same a, amt = 3 left -> 8'b10011100. amt = 5 left -> 8'b01110010. amt = 3 right -> 8'b01110010. amt = 0 either direction -> 8'b10010011.
3. req0 and req1 valid on the same cycle from reset, req0_a = 8'h01, amt = 1, left; req1_a = 8'h80, amt = 1, right; both held: req0 served first (out_y = 8'h02, id 0), then req1 (out_y = 8'h40, id 1). Continuous requests alternate 0, 1, 0, 1.
4. Backpressure: out_ready = 0 for 5 cycles after out_valid rises: out_y and out_id stable, out_valid held, req ready stays 0. Raise out_ready: out_valid clears next edge and the next grant follows in IDLE.
5. Reset asserted during EXEC and during DONE: out_valid = 0 on the next edge, state IDLE, no result appears. With both requesters valid afterwards, requester 0 is granted first.
6. Random 1000 requests with random out_ready: each result matches a reference rotate model, there is no lost or duplicated request, and ready is never high for both requesters at once.
